// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: buffers 16-bit mono samples in a small FIFO and plays
// each one MSB-first on both I2S channel slots, with bclk/lrclk made from clk.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   valid/sample_in - sample write from the effects pipeline
//   ready           - FIFO not full
//   fifo_level      - FIFO occupancy
//   underrun        - one-clk pulse: frame started with the FIFO empty
//   overflow        - one-clk pulse: write while full, sample dropped
//   bclk/lrclk/sdata- I2S bit clock, word select (0=left), serial data
module i2s_tx_serializer #(
  parameter int unsigned SLEN       = 16,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid,
  input  logic [SLEN-1:0]                 sample_in,
  output logic                            ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            underrun,
  output logic                            overflow,
  output logic                            bclk,
  output logic                            lrclk,
  output logic                            sdata
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(2 * SLOT_W);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic [SLEN-1:0]  frame_q, frame_d;
  logic [SLEN-1:0]  shift_q, shift_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ready_q, ready_d;
  logic             underrun_q, underrun_d;
  logic             overflow_q, overflow_d;
  logic [SLEN-1:0]  mem_q [FIFO_DEPTH];

  logic             tick_c;
  logic             fall_c;
  logic             wr_en_c;
  logic             rd_en_c;
  logic [BIT_W-1:0] pos_c;

  // Next-state logic: divider, bit counter, slot serializer and FIFO bookkeeping
  always_comb begin
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    frame_d    = frame_q;
    shift_d    = shift_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    underrun_d = 1'b0;
    overflow_d = 1'b0;
    wr_en_c    = 1'b0;
    rd_en_c    = 1'b0;
    pos_c      = '0;

    tick_c = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    fall_c = tick_c && bclk_q;

    if (tick_c) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    // lrclk/sdata only move on the bclk falling edge so they are stable at every rise
    if (fall_c) begin
      bit_cnt_d = (bit_cnt_q == BIT_W'(2 * SLOT_W - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
      lrclk_d   = (bit_cnt_d >= BIT_W'(SLOT_W));
      pos_c     = lrclk_d ? (bit_cnt_d - BIT_W'(SLOT_W)) : bit_cnt_d;

      // Frame start: no bypass, a write landing this same cycle is not visible to the pop
      if (bit_cnt_d == '0) begin
        if (level_q != '0) begin
          rd_en_c  = 1'b1;
          frame_d  = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
          frame_d    = '0;
          underrun_d = 1'b1;
        end
      end

      // Slot position 0 is the I2S one-bit delay; reload the shifter for each slot
      if (pos_c == '0) begin
        shift_d = frame_d;
        sdata_d = 1'b0;
      end else if (pos_c <= BIT_W'(SLEN)) begin
        sdata_d = shift_q[SLEN-1];
        shift_d = shift_q << 1;
      end else begin
        sdata_d = 1'b0;
      end
    end

    if (valid) begin
      if (ready_q) begin
        wr_en_c  = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end

    level_d = level_q + LVL_W'(wr_en_c) - LVL_W'(rd_en_c);
    ready_d = (level_d != LVL_W'(FIFO_DEPTH));
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= BIT_W'(2 * SLOT_W - 1);
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      frame_q    <= '0;
      shift_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      frame_q    <= frame_d;
      shift_q    <= shift_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // Sample storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && wr_en_c) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign ready      = ready_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;
  assign overflow   = overflow_q;
  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: directed steps plus random writes,
// compared every cycle against a timeline/queue model of the I2S stream.
module tb_i2s_tx_serializer;

  localparam int SLEN     = 16;
  localparam int SLOT_W   = 32;
  localparam int BCLK_DIV = 4;
  localparam int DEPTH    = 4;
  localparam int BP       = 2 * BCLK_DIV;      // clk cycles per bclk period
  localparam int FP       = 2 * SLOT_W * BP;   // clk cycles per frame

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] sample_in;
  logic        ready;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic        overflow;
  logic        bclk;
  logic        lrclk;
  logic        sdata;

  always #5 clk = ~clk;

  i2s_tx_serializer #(
    .SLEN(SLEN), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .sample_in(sample_in),
    .ready(ready), .fifo_level(fifo_level), .underrun(underrun),
    .overflow(overflow), .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: t = clk edges since the last reset edge
  int          t = 0;
  logic [15:0] mq[$];
  logic [15:0] cur_frame = 16'h0;
  logic        exp_under = 1'b0;
  logic        exp_over  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=0x%0h expected=0x%0h", tag, t, obs, exp);
    end
  endtask

  // One clk edge of the reference: pop at frame start (pre-edge level), then accept/drop write
  task automatic model_edge(input logic r, input logic v, input logic [15:0] s);
    int pre;
    exp_under = 1'b0;
    exp_over  = 1'b0;
    if (r) begin
      t = 0;
      mq.delete();
      cur_frame = 16'h0;
      return;
    end
    t++;
    pre = mq.size();
    if (t >= BP && (t % BP) == 0 && ((t / BP - 1) % (2 * SLOT_W)) == 0) begin
      if (pre > 0) cur_frame = mq.pop_front();
      else begin
        cur_frame = 16'h0;
        exp_under = 1'b1;
      end
    end
    if (v) begin
      if (pre != DEPTH) mq.push_back(s);
      else exp_over = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int k, b, p;
    logic e_lr, e_sd, e_bclk;
    logic [15:0] tmp;
    e_bclk = ((t / BCLK_DIV) % 2) == 1;
    e_lr = 1'b0;
    e_sd = 1'b0;
    if (t >= BP) begin
      k = t / BP;
      b = (k - 1) % (2 * SLOT_W);
      e_lr = (b >= SLOT_W);
      p = b % SLOT_W;
      if (p >= 1 && p <= SLEN) begin
        tmp  = cur_frame >> (SLEN - p);
        e_sd = tmp[0];
      end
    end
    check("bclk",       32'(bclk),       32'(e_bclk));
    check("lrclk",      32'(lrclk),      32'(e_lr));
    check("sdata",      32'(sdata),      32'(e_sd));
    check("ready",      32'(ready),      32'(mq.size() != DEPTH));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("underrun",   32'(underrun),   32'(exp_under));
    check("overflow",   32'(overflow),   32'(exp_over));
  endtask

  task automatic tick(input bit chk);
    logic r, v;
    logic [15:0] s;
    r = rst;
    v = valid;
    s = sample_in;
    @(posedge clk);
    model_edge(r, v, s);
    #1;
    if (chk) check_outputs();
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (t < target && guard < 100000) begin
      tick(1'b1);
      guard++;
    end
  endtask

  // Runs exactly one frame starting one cycle before its start; gathers the
  // 16 data bits of each slot as sampled on bclk rises, plus underrun pulses
  task automatic capture_frame(output logic [15:0] lw, output logic [15:0] rw, output int nu);
    int r, p;
    logic pb;
    r  = 0;
    lw = 16'h0;
    rw = 16'h0;
    nu = 0;
    pb = bclk;
    for (int i = 0; i < FP; i++) begin
      tick(1'b1);
      if (underrun) nu++;
      if (bclk && !pb) begin
        p = r % SLOT_W;
        if (p >= 1 && p <= SLEN) begin
          if (r < SLOT_W) lw = {lw[14:0], sdata};
          else            rw = {rw[14:0], sdata};
        end
        r++;
      end
      pb = bclk;
    end
  endtask

  logic [15:0] lw, rw;
  int          nu, ones;
  logic [15:0] exp_words [5];

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    sample_in = 16'h0;

    // Reset held three cycles
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_sdata", 32'(sdata), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1);
      check("bclk_first_edges", 32'(bclk), 32'((i >= 4 && i < 8) ? 1 : 0));
    end

    // Single sample: plays in frame 1 on both slots
    valid = 1'b1;
    sample_in = 16'hA5C3;
    tick(1'b1);
    valid = 1'b0;
    check("single_level", 32'(fifo_level), 32'd1);
    run_to(FP + BP - 1);
    capture_frame(lw, rw, nu);
    check("single_left", 32'(lw), 32'h0000A5C3);
    check("single_right", 32'(rw), 32'h0000A5C3);
    check("single_no_underrun", 32'(nu), 32'd0);
    check("single_level_after", 32'(fifo_level), 32'd0);

    // Empty FIFO for three frames
    nu = 0;
    ones = 0;
    for (int i = 0; i < 3 * FP; i++) begin
      tick(1'b1);
      if (underrun) nu++;
      if (sdata) ones++;
    end
    check("empty_underruns", 32'(nu), 32'd3);
    check("empty_sdata_ones", 32'(ones), 32'd0);

    // Overflow: six back-to-back writes mid-frame
    run_to(5 * FP + 200);
    for (int i = 1; i <= 6; i++) begin
      valid = 1'b1;
      sample_in = 16'(i);
      tick(1'b1);
      if (i == 4) begin
        check("ovf_ready_low", 32'(ready), 32'd0);
        check("ovf_level_full", 32'(fifo_level), 32'd4);
      end
      if (i >= 5) check("ovf_pulse", 32'(overflow), 32'd1);
    end
    valid = 1'b0;
    exp_words[0] = 16'd1;
    exp_words[1] = 16'd2;
    exp_words[2] = 16'd3;
    exp_words[3] = 16'd4;
    exp_words[4] = 16'd0;
    for (int f = 0; f < 5; f++) begin
      run_to((6 + f) * FP + BP - 1);
      capture_frame(lw, rw, nu);
      check("ovf_order_left", 32'(lw), 32'(exp_words[f]));
      check("ovf_order_right", 32'(rw), 32'(exp_words[f]));
      check("ovf_underrun", 32'(nu), 32'((f == 4) ? 1 : 0));
    end

    // Write landing exactly on a frame-start cycle with an empty FIFO
    run_to(11 * FP + BP - 1);
    valid = 1'b1;
    sample_in = 16'h7FFF;
    tick(1'b1);
    valid = 1'b0;
    check("same_edge_underrun", 32'(underrun), 32'd1);
    check("same_edge_level", 32'(fifo_level), 32'd1);
    ones = 0;
    while (t < 12 * FP + BP - 1) begin
      tick(1'b1);
      if (sdata) ones++;
    end
    check("same_edge_zero_frame", 32'(ones), 32'd0);
    capture_frame(lw, rw, nu);
    check("same_edge_next_left", 32'(lw), 32'h00007FFF);
    check("same_edge_next_right", 32'(rw), 32'h00007FFF);
    check("same_edge_level_after", 32'(fifo_level), 32'd0);

    // Reset in the left slot at p=10 with two samples queued
    run_to(13 * FP + 20);
    valid = 1'b1;
    sample_in = 16'h1234;
    tick(1'b1);
    sample_in = 16'h5678;
    tick(1'b1);
    valid = 1'b0;
    run_to(BP * (64 * 13 + 11));
    check("midrst_left_slot", 32'(lrclk), 32'd0);
    check("midrst_level_before", 32'(fifo_level), 32'd2);
    rst = 1'b1;
    tick(1'b1);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_bclk", 32'(bclk), 32'd0);
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      run_to(f * FP + BP - 1);
      capture_frame(lw, rw, nu);
      check("midrst_flushed_left", 32'(lw), 32'd0);
      check("midrst_flushed_right", 32'(rw), 32'd0);
      check("midrst_underrun", 32'(nu), 32'd1);
    end

    // Random sparse writes with random data
    for (int i = 0; i < 6 * FP; i++) begin
      valid = ($urandom_range(0, 299) == 0);
      sample_in = 16'($urandom_range(0, 65535));
      tick(1'b1);
    end
    valid = 1'b0;
    for (int i = 0; i < FP; i++) tick(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
Downstream output stage for the effects pipeline. It accepts processed 16-bit mono samples (sample_out + valid) into a small FIFO. It generates I2S bit and word clocks from clk and shifts each sample MSB-first to the audio DAC, duplicated onto the left and right slots. Underrun and overflow are flagged so the pipeline can be checked for rate matching.

Parameters:
SLEN, 16, sample width in bits (two's complement, sent unchanged)
SLOT_W, 32, bit clocks per channel slot; constraint SLOT_W >= SLEN+1
BCLK_DIV, 4, clk cycles per bclk half-period; constraint >= 1
FIFO_DEPTH, 4, sample FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
valid  in  1  sample_in qualifier from effects pipeline
sample_in  in  SLEN  processed sample
ready  out  1  FIFO not full
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
underrun  out  1  one-clk pulse: frame started with FIFO empty
overflow  out  1  one-clk pulse: valid while not ready, sample dropped
bclk  out  1  I2S bit clock
lrclk  out  1  I2S word select (0 = left, 1 = right)
sdata  out  1  I2S serial data

Behaviour:
- Reset is synchronous (rst sampled on the clk rising edge) and has priority over everything, including mid-frame. After reset:
  - bclk=0, lrclk=0, sdata=0, ready=1, fifo_level=0, underrun=0, overflow=0.
  - div_cnt=0, bit_cnt=2*SLOT_W-1, FIFO flushed, frame register=0.
- Clock divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - When div_cnt==BCLK_DIV-1, bclk toggles on that clk edge.
  - First bclk rise is BCLK_DIV clk cycles after rst deasserts; first fall is 2*BCLK_DIV cycles after.
- Falling-edge event (the clk edge where bclk goes 1->0):
  - bit_cnt advances modulo 2*SLOT_W.
  - lrclk and sdata update on this edge only, so they are stable across every bclk rise.
- lrclk = 0 while new bit_cnt < SLOT_W, otherwise 1.
- Slot position p = new bit_cnt mod SLOT_W. I2S one-bit delay:
  - p = 1..SLEN: sdata = frame[SLEN-p] (MSB at p=1).
  - p = 0 or p > SLEN: sdata = 0.
- Frame start is the falling-edge event where bit_cnt becomes 0.
  - If the FIFO is non-empty: pop the head into the frame register, and decrement fifo_level unless a write occurs on the same edge.
  - If the FIFO is empty: frame register = 0 and underrun=1 for that clk cycle.
  - The frame register is held for both slots, so left and right carry identical data.
- FIFO write:
  - When valid && ready: push sample_in, fifo_level+1.
  - When valid && !ready: sample dropped, overflow=1 for one cycle, FIFO unchanged.
  - ready = (fifo_level != FIFO_DEPTH), registered from next-state level.
- Simultaneous write and pop:
  - fifo_level unchanged.
  - There is no bypass: a write landing on an empty FIFO in the frame-start cycle is not seen by that pop. The result is underrun and the sample plays next frame.
- Pop when full and write in the same cycle: ready was 0, so the write is dropped with overflow. ready returns to 1 the next cycle.
- Frame period = 2*SLOT_W*2*BCLK_DIV clk cycles (512 at defaults). Sustained input rate must not exceed one sample per frame.
- Pointers wrap modulo FIFO_DEPTH. Output order strictly equals accepted input order.

Test Plan:
1. Reset: hold rst 3 cycles, then release.
   -> All outputs 0 except ready=1; first bclk rise at cycle 4 after release, first fall at cycle 8.
2. Single sample: push 16'hA5C3 once after reset.
   -> First frame, left slot (lrclk=0, 32 bclks): p=0 is 0, p=1..16 = 1010010111000011, p=17..31 are 0.
   -> Right slot (lrclk=1): identical bits. fifo_level 1 -> 0 at frame start.
3. Empty FIFO: no writes for 3 frames.
   -> underrun pulses exactly once per frame start, sdata constantly 0, lrclk toggles every 32 bclks.
4. Overflow: 6 consecutive valid cycles (values 1..6) well away from a frame start.
   -> ready drops after the 4th write, fifo_level=4, overflow pulses on writes 5 and 6.
   -> Following frames output 1,2,3,4 then underrun.
5. Same-edge write/pop: FIFO empty, valid asserted exactly on a frame-start cycle with 16'h7FFF.
   -> underrun=1, current frame all zeros, next frame carries 7FFF, fifo_level 1 then 0.
6. Reset mid-frame: rst asserted at left-slot p=10 with 2 samples queued.
   -> Next cycle all outputs and FIFO return to reset values; queued samples never appear on sdata.
